// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - iterative AES-128 key schedule, one round key per clock
// Streams round keys 0..NR to the cipher core and keeps them in a readable key file.
module aes_key_expand #(
  parameter int NR = 10
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         rk_valid,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  // Forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t        state, state_next;
  logic [3:0]    cnt;
  logic [127:0]  w, w_next;
  logic [127:0]  file [0:NR];
  logic          accept;
  logic [31:0]   w0, w1, w2, w3, rot, t, n0, n1, n2, n3;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign {w0, w1, w2, w3} = w;
  assign rot    = {w3[23:0], w3[31:24]};
  assign t      = {sbox(rot[31:24]) ^ rcon(cnt), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign n0     = w0 ^ t;
  assign n1     = w1 ^ n0;
  assign n2     = w2 ^ n1;
  assign n3     = w3 ^ n2;
  assign w_next = {n0, n1, n2, n3};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_next = EXPAND;
      end
      EXPAND: begin
        busy = 1'b1;
        if (cnt == 4'(NR)) state_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        accept = start;
        if (start) state_next = EXPAND;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt      <= '0;
      w        <= '0;
      rk_valid <= 1'b0;
      rk_idx   <= '0;
      rk_out   <= '0;
      for (int i = 0; i <= NR; i++) file[i] <= '0;
    end else if (accept) begin
      cnt      <= 4'd1;
      w        <= key_in;
      file[0]  <= key_in;
      rk_valid <= 1'b1;
      rk_idx   <= 4'd0;
      rk_out   <= key_in;
    end else if (state == EXPAND) begin
      w         <= w_next;
      file[cnt] <= w_next;
      rk_valid  <= 1'b1;
      rk_idx    <= cnt;
      rk_out    <= w_next;
      if (cnt != 4'(NR)) cnt <= cnt + 4'd1;
    end else begin
      rk_valid <= 1'b0;
    end
  end

  // Indices past the last round key read as zero.
  assign rd_key = (rd_idx <= 4'(NR)) ? file[rd_idx] : '0;

endmodule

// File: tb/tb_aes_key_expand.sv
// tb/tb_aes_key_expand.sv - directed vector bench for aes_key_expand
// Key vectors with known round keys 1 and 10, plus reset and restart sequences.
module tb_aes_key_expand;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         start;
  logic [127:0] key_in;
  logic         busy, done, rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  int total = 0;
  int bad   = 0;

  aes_key_expand dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .key_in(key_in),
    .busy(busy), .done(done), .rk_valid(rk_valid), .rk_idx(rk_idx),
    .rk_out(rk_out), .rd_idx(rd_idx), .rd_key(rd_key)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [127:0] key;
    logic [127:0] rk1;
    logic [127:0] rk10;
    int           glitch;
    logic         from_done;
    string        tag;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start an expansion at the next edge; optionally pulse start again at edge `glitch`.
  task automatic run_expand(input vec_t v);
    int           vcount;
    int           done_cyc;
    bit           seq_ok;
    logic [127:0] got1, got10;
    vcount = 0; done_cyc = -1; seq_ok = 1'b1; got1 = '0; got10 = '0;
    @(negedge CLK);
    start  = 1'b1;
    key_in = v.key;
    for (int c = 0; c < 15; c++) begin
      @(posedge CLK);
      #1;
      start  = (v.glitch != 0) && (c + 1 == v.glitch);
      key_in = ~v.key;
      @(negedge CLK);
      if (rk_valid) begin
        if (rk_idx != 4'(vcount)) seq_ok = 1'b0;
        if (vcount == 0 && rk_out !== v.key) seq_ok = 1'b0;
        if (rk_idx == 4'd1)  got1  = rk_out;
        if (rk_idx == 4'd10) got10 = rk_out;
        vcount++;
      end
      if (done && done_cyc < 0) done_cyc = c;
      if (c == 0) begin
        check({v.tag, "_busy_at_start"}, 128'(busy), 128'd1);
        if (v.from_done) check({v.tag, "_done_falls"}, 128'(done), 128'd0);
      end
      if (c == 9) check({v.tag, "_busy_edge9"}, 128'(busy), 128'd1);
      if (c == 10) check({v.tag, "_busy_edge10"}, 128'(busy), 128'd0);
    end
    check({v.tag, "_valid_count"}, 128'(vcount), 128'd11);
    check({v.tag, "_idx_sequence"}, 128'(seq_ok), 128'd1);
    check({v.tag, "_rk1"}, got1, v.rk1);
    check({v.tag, "_rk10"}, got10, v.rk10);
    check({v.tag, "_done_latency"}, 128'(done_cyc), 128'd10);
    rd_idx = 4'd0;  #1 check({v.tag, "_rd0"}, rd_key, v.key);
    rd_idx = 4'd1;  #1 check({v.tag, "_rd1"}, rd_key, v.rk1);
    rd_idx = 4'd10; #1 check({v.tag, "_rd10"}, rd_key, v.rk10);
    rd_idx = 4'd12; #1 check({v.tag, "_rd12"}, rd_key, 128'h0);
  endtask

  initial begin
    logic [127:0] acc;
    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0, 1'b0, "fips"};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                128'h13111d7fe3944a17f307a78b4d2b30c5, 0, 1'b1, "seqkey"};
    vecs[2] = '{128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                128'h13111d7fe3944a17f307a78b4d2b30c5, 4, 1'b1, "busy_start"};
    vecs[3] = '{128'h0, 128'h62636363626363636263636362636363,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e, 0, 1'b1, "zerokey"};
    vecs[4] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1, 1'b0, "double_start"};

    RST_N = 1'b0; start = 1'b0; key_in = '0; rd_idx = '0;
    repeat (3) @(negedge CLK);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_rk_valid", 128'(rk_valid), 128'd0);
    check("rst_rk_idx", 128'(rk_idx), 128'd0);
    check("rst_rk_out", rk_out, 128'h0);
    check("rst_rd0", rd_key, 128'h0);
    RST_N = 1'b1;

    for (int i = 0; i < 4; i++) run_expand(vecs[i]);

    // Reset in the middle of an expansion clears everything at once.
    @(negedge CLK);
    start = 1'b1; key_in = vecs[0].key;
    @(negedge CLK);
    start = 1'b0;
    repeat (4) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("rstmid_busy", 128'(busy), 128'd0);
    check("rstmid_done", 128'(done), 128'd0);
    check("rstmid_rk_valid", 128'(rk_valid), 128'd0);
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1 acc = acc | rd_key;
    end
    check("rstmid_file", acc, 128'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);
    check("idle_hold_busy", 128'(busy), 128'd0);
    check("idle_hold_done", 128'(done), 128'd0);
    check("idle_hold_rk_valid", 128'(rk_valid), 128'd0);

    run_expand(vecs[4]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
